// File: rtl/apb_reg_slave.sv
// APB completer with a bank of byte-strobed registers, fixed wait states and
// error response for misaligned, out-of-range, read-only and unprivileged accesses.
module apb_reg_slave #(
    parameter int                ADDR_WIDTH  = 32,
    parameter int                DATA_WIDTH  = 32,
    parameter int                STRB_WIDTH  = 4,
    parameter int                NUM_REGS    = 16,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA5B0_0001
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [STRB_WIDTH-1:0] pstrb,
    input  logic [2:0]            pprot,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W = $clog2(NUM_REGS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]            r_state;
    logic [3:0]            r_count;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic [1:0]            w_phase;
    logic [1:0]            w_state_nxt;
    logic [3:0]            w_count_nxt;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_misalign;
    logic                  w_out_of_range;
    logic                  w_wr_err;
    logic                  w_err;
    logic                  w_ready;
    logic                  w_commit;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused;

    // The setup phase is the cycle psel rises with penable low; decoding it
    // combinationally lets the wait counter load on that same edge.
    always_comb begin
        w_phase = r_state;
        if (r_state != ST_ACCESS && psel && !penable) begin
            w_phase = ST_SETUP;
        end
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = 4'd0;
        case (w_phase)
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
                w_count_nxt = 4'(WAIT_CYCLES);
            end
            ST_ACCESS: begin
                if (psel && penable && r_count != 4'd0) begin
                    w_state_nxt = ST_ACCESS;
                    w_count_nxt = r_count - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
            r_count <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign w_idx          = paddr[IDX_W+1:2];
    assign w_misalign     = (paddr[1:0] != 2'b00);
    assign w_out_of_range = |paddr[ADDR_WIDTH-1:IDX_W+2];
    assign w_wr_err       = pwrite && ((w_idx == '0) || !pprot[0]);
    assign w_err          = w_misalign || w_out_of_range || w_wr_err;

    assign w_ready  = (r_state == ST_ACCESS) && (r_count == 4'd0) && psel && penable;
    assign w_commit = w_ready && pwrite && !w_err;
    assign w_rdata  = (w_idx == '0) ? ID_VALUE : r_regs[w_idx];

    assign pready  = w_ready;
    assign pslverr = w_ready && w_err;
    assign prdata  = (w_ready && !pwrite && !w_err) ? w_rdata : '0;

    assign w_unused = ^pprot[2:1];

    // Register 0 is backed by ID_VALUE; its storage slot is never written.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (pstrb[b]) begin
                    r_regs[w_idx][8*b +: 8] <= pwdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: unit 0 uses two wait states, unit 1 is
// a zero-wait build driven with random traffic against a reference model.
module tb_apb_reg_slave;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } expT;

    localparam logic [31:0] ID = 32'hA5B0_0001;

    logic        pclk = 1'b0;
    logic        presetn;
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic        pready  [2];
    logic        pslverr [2];
    logic [3:0]  pstrb   [2];
    logic [2:0]  pprot   [2];

    expT q0[$];
    expT q1[$];
    int  vectors     = 0;
    int  miscompares = 0;
    logic [31:0] model [16];

    always #5 pclk = ~pclk;

    apb_reg_slave #(.WAIT_CYCLES(2)) dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr[0]), .psel(psel[0]),
        .penable(penable[0]), .pwrite(pwrite[0]), .pwdata(pwdata[0]),
        .pstrb(pstrb[0]), .pprot(pprot[0]), .prdata(prdata[0]),
        .pready(pready[0]), .pslverr(pslverr[0])
    );

    apb_reg_slave #(.WAIT_CYCLES(0)) dutZw (
        .pclk(pclk), .presetn(presetn), .paddr(paddr[1]), .psel(psel[1]),
        .penable(penable[1]), .pwrite(pwrite[1]), .pwdata(pwdata[1]),
        .pstrb(pstrb[1]), .pprot(pprot[1]), .prdata(prdata[1]),
        .pready(pready[1]), .pslverr(pslverr[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Monitor: pops the expected response whenever a unit completes a transfer
    // and flags any output activity outside a qualified completion cycle.
    always @(negedge pclk) begin
        expT e;
        logic got;
        for (int u = 0; u < 2; u++) begin
            if (pready[u] && !(psel[u] && penable[u])) begin
                miscompares++;
                $display("[TB] FAIL pready_unqualified unit %0d: got pready=1, expected 0", u);
            end
            if (!pready[u] && (prdata[u] !== 32'h0 || pslverr[u] !== 1'b0)) begin
                miscompares++;
                $display("[TB] FAIL idle_outputs unit %0d: got prdata=%h pslverr=%b, expected 0", u, prdata[u], pslverr[u]);
            end
            if (pready[u] === 1'b1) begin
                got = 1'b0;
                if (u == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                if (u == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                if (!got) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_pready unit %0d: got pready=1 with empty scoreboard, expected 0", u);
                end else begin
                    checkOutput($sformatf("prdata_u%0d", u), prdata[u], e.data);
                    checkOutput($sformatf("pslverr_u%0d", u), {31'h0, pslverr[u]}, {31'h0, e.err});
                end
            end
        end
    end

    // One APB transfer; caller is positioned just after a rising edge.
    task automatic applyStimulus(input int u, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 input logic [2:0] prot, input logic [31:0] expData,
                                 input logic expErr, input int expAccess, input logic keepSel);
        int cyc;
        expT e;
        e.data = expData;
        e.err  = expErr;
        if (u == 0) q0.push_back(e); else q1.push_back(e);
        psel[u]    = 1'b1;
        penable[u] = 1'b0;
        pwrite[u]  = wr;
        paddr[u]   = addr;
        pwdata[u]  = wdata;
        pstrb[u]   = strb;
        pprot[u]   = prot;
        @(posedge pclk); #1;
        penable[u] = 1'b1;
        cyc = 0;
        forever begin
            @(negedge pclk);
            cyc++;
            if (pready[u] === 1'b1) break;
            if (cyc > 40) break;
        end
        checkOutput($sformatf("access_cycles_u%0d_addr%h", u, addr), 32'(cyc), 32'(expAccess));
        @(posedge pclk); #1;
        penable[u] = 1'b0;
        if (!keepSel) psel[u] = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  s;
        int          idx;
        for (int u = 0; u < 2; u++) begin
            psel[u] = 1'b0; penable[u] = 1'b0; pwrite[u] = 1'b0; paddr[u] = '0;
            pwdata[u] = '0; pstrb[u] = '0; pprot[u] = '0;
        end
        for (int i = 0; i < 16; i++) model[i] = '0;
        presetn = 1'b0;
        repeat (3) @(posedge pclk);
        #1 presetn = 1'b1;
        @(negedge pclk);
        checkOutput("reset_pready", {31'h0, pready[0]}, 32'h0);
        checkOutput("reset_prdata", prdata[0], 32'h0);
        checkOutput("reset_pslverr", {31'h0, pslverr[0]}, 32'h0);
        @(posedge pclk); #1;

        applyStimulus(0, 0, 32'h00, 0, 4'h0, 3'b000, ID, 0, 3, 0);
        applyStimulus(0, 0, 32'h14, 0, 4'h0, 3'b000, 32'h0, 0, 3, 0);
        applyStimulus(0, 1, 32'h14, 32'hDEAD_BEEF, 4'hF, 3'b001, 32'h0, 0, 3, 0);
        applyStimulus(0, 1, 32'h14, 32'h1122_3344, 4'b0101, 3'b001, 32'h0, 0, 3, 0);
        applyStimulus(0, 0, 32'h14, 0, 4'h0, 3'b001, 32'hDE22_BE44, 0, 3, 0);
        applyStimulus(0, 1, 32'h00, 32'hFFFF_FFFF, 4'hF, 3'b001, 32'h0, 1, 3, 0);
        applyStimulus(0, 0, 32'h40, 0, 4'h0, 3'b001, 32'h0, 1, 3, 0);
        applyStimulus(0, 0, 32'h13, 0, 4'h0, 3'b001, 32'h0, 1, 3, 0);
        applyStimulus(0, 1, 32'h14, 32'hFFFF_FFFF, 4'hF, 3'b000, 32'h0, 1, 3, 0);
        applyStimulus(0, 1, 32'h14, 32'h0000_0000, 4'h0, 3'b001, 32'h0, 0, 3, 0);
        applyStimulus(0, 0, 32'h14, 0, 4'hF, 3'b000, 32'hDE22_BE44, 0, 3, 0);
        applyStimulus(0, 0, 32'h00, 0, 4'h0, 3'b001, ID, 0, 3, 0);

        applyStimulus(0, 1, 32'h08, 32'hCAFE_F00D, 4'hF, 3'b001, 32'h0, 0, 3, 1);
        applyStimulus(0, 0, 32'h08, 0, 4'h0, 3'b001, 32'hCAFE_F00D, 0, 3, 0);

        // Abandoned write: psel drops one cycle into the access phase.
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h08;
        pwdata[0] = 32'h0; pstrb[0] = 4'hF; pprot[0] = 3'b001;
        @(posedge pclk); #1 penable[0] = 1'b1;
        @(posedge pclk); #1 begin psel[0] = 1'b0; penable[0] = 1'b0; end
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            checkOutput("abort_pready", {31'h0, pready[0]}, 32'h0);
        end
        @(posedge pclk); #1;
        applyStimulus(0, 0, 32'h08, 0, 4'h0, 3'b001, 32'hCAFE_F00D, 0, 3, 0);

        // Reset arriving mid-access of a write to register 3.
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h0C;
        pwdata[0] = 32'h1234_5678; pstrb[0] = 4'hF; pprot[0] = 3'b001;
        @(posedge pclk); #1 penable[0] = 1'b1;
        @(posedge pclk); #1 presetn = 1'b0;
        #1;
        checkOutput("rst_mid_pready", {31'h0, pready[0]}, 32'h0);
        checkOutput("rst_mid_prdata", prdata[0], 32'h0);
        checkOutput("rst_mid_pslverr", {31'h0, pslverr[0]}, 32'h0);
        repeat (3) @(posedge pclk);
        #1 begin psel[0] = 1'b0; penable[0] = 1'b0; end
        @(posedge pclk); #1 presetn = 1'b1;
        @(posedge pclk); #1;
        applyStimulus(0, 0, 32'h0C, 0, 4'h0, 3'b001, 32'h0, 0, 3, 0);
        applyStimulus(0, 0, 32'h14, 0, 4'h0, 3'b001, 32'h0, 0, 3, 0);
        applyStimulus(0, 0, 32'h08, 0, 4'h0, 3'b001, 32'h0, 0, 3, 0);

        // Zero-wait unit: write then read back the same index.
        for (int i = 0; i < 8; i++) begin
            idx = $urandom_range(1, 15);
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            end
            applyStimulus(1, 1, 32'(idx * 4), d, s, 3'b001, 32'h0, 0, 1, 0);
            applyStimulus(1, 0, 32'(idx * 4), 0, 4'h0, 3'b001, model[idx], 0, 1, 0);
        end
        applyStimulus(1, 0, 32'h00, 0, 4'h0, 3'b000, ID, 0, 1, 0);

        repeat (3) @(posedge pclk);
        checkOutput("scoreboard_drained_u0", 32'(q0.size()), 32'h0);
        checkOutput("scoreboard_drained_u1", 32'(q1.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
